// File: rtl/normalizer_engine_if.sv
// Bus bundle for the normaliser datapath: control inputs,
// Avalon master signals and status outputs.
interface normalizer_engine_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] stop_addr;
    logic [15:0]       max_value;
    logic [ADDR_W-1:0] avm_m0_address;
    logic              avm_m0_read;
    logic              avm_m0_write;
    logic [31:0]       avm_m0_writedata;
    logic [31:0]       avm_m0_readdata;
    logic              avm_m0_readdatavalid;
    logic              avm_m0_waitrequest;
    logic              busy;
    logic              done;
    logic [16:0]       peak;

    modport master (
        input  start, start_addr, stop_addr, max_value,
        input  avm_m0_readdata, avm_m0_readdatavalid,
        input  avm_m0_waitrequest,
        output avm_m0_address, avm_m0_read, avm_m0_write,
        output avm_m0_writedata, busy, done, peak
    );

    modport slave (
        output start, start_addr, stop_addr, max_value,
        output avm_m0_readdata, avm_m0_readdatavalid,
        output avm_m0_waitrequest,
        input  avm_m0_address, avm_m0_read, avm_m0_write,
        input  avm_m0_writedata, busy, done, peak
    );
endinterface

// File: rtl/normalizer_engine.sv
// Two-pass amplitude normaliser: peak scan, serial divide,
// then in-place rescale of a 16-bit sample buffer.
module normalizer_engine #(
    parameter int FRAC   = 16,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    normalizer_engine_if.master bus
);
    localparam int AW = ADDR_W - 2;
    localparam int DW = 16 + FRAC;

    typedef enum logic [2:0] {
        IDLE, SCAN_RD, SCAN_WT, DIV,
        NORM_RD, NORM_WT, NORM_WR, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   stop_q, stop_d;
    logic [15:0]     maxv_q, maxv_d;
    logic [15:0]     x_q, x_d;
    logic [16:0]     peak_q, peak_d;
    logic [31:0]     scale_q, scale_d;
    logic [DW-1:0]   dvd_q, dvd_d;
    logic [31:0]     quo_q, quo_d;
    logic [17:0]     rem_q, rem_d;
    logic [5:0]      cnt_q, cnt_d;

    logic [15:0]        rd_x;
    logic [16:0]        rd_abs;
    logic [16:0]        peak_new;
    logic [AW-1:0]      ptr_inc;
    logic               last;
    logic [17:0]        trial;
    logic               fits;
    logic [17:0]        rem_sub;
    logic signed [48:0] xs, ss, prod, sh;
    logic [15:0]        y;
    logic               rd_en, wr_en;
    logic               unused_ok;

    assign rd_x     = bus.avm_m0_readdata[15:0];
    assign rd_abs   = rd_x[15] ? (17'd0 - {1'b1, rd_x})
                               : {1'b0, rd_x};
    assign peak_new = (rd_abs > peak_q) ? rd_abs : peak_q;
    assign ptr_inc  = ptr_q + AW'(1);
    assign last     = (ptr_inc == stop_q);

    assign trial   = {rem_q[16:0], dvd_q[DW-1]};
    assign fits    = (trial >= {1'b0, peak_q});
    assign rem_sub = trial - {1'b0, peak_q};

    assign xs   = {{33{x_q[15]}}, x_q};
    assign ss   = {17'd0, scale_q};
    assign prod = xs * ss;
    assign sh   = prod >>> FRAC;

    // Saturate the scaled sample into the signed 16-bit range
    always_comb begin
        y = sh[15:0];
        if (sh > 49'sd32767)
            y = 16'h7FFF;
        else if (sh < -49'sd32768)
            y = 16'h8000;
    end

    assign unused_ok = ^{bus.avm_m0_readdata[31:16],
                         bus.start_addr[1:0],
                         bus.stop_addr[1:0]};

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            base_q  <= '0;
            stop_q  <= '0;
            maxv_q  <= '0;
            x_q     <= '0;
            peak_q  <= '0;
            scale_q <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            base_q  <= base_d;
            stop_q  <= stop_d;
            maxv_q  <= maxv_d;
            x_q     <= x_d;
            peak_q  <= peak_d;
            scale_q <= scale_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state sequencing for scan, divide and rewrite passes
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        base_d  = base_q;
        stop_d  = stop_q;
        maxv_d  = maxv_q;
        x_d     = x_q;
        peak_d  = peak_q;
        scale_d = scale_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d = bus.start_addr[ADDR_W-1:2];
                    ptr_d  = bus.start_addr[ADDR_W-1:2];
                    stop_d = bus.stop_addr[ADDR_W-1:2];
                    maxv_d = bus.max_value;
                    peak_d = '0;
                    if (bus.stop_addr[ADDR_W-1:2]
                        <= bus.start_addr[ADDR_W-1:2])
                        state_d = DONE;
                    else
                        state_d = SCAN_RD;
                end
            end
            SCAN_RD: begin
                if (!bus.avm_m0_waitrequest)
                    state_d = SCAN_WT;
            end
            SCAN_WT: begin
                if (bus.avm_m0_readdatavalid) begin
                    peak_d = peak_new;
                    ptr_d  = ptr_inc;
                    if (!last) begin
                        state_d = SCAN_RD;
                    end else if (peak_new == 17'd0) begin
                        state_d = DONE;
                    end else begin
                        dvd_d   = {maxv_q, {FRAC{1'b0}}};
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                rem_d = fits ? rem_sub : trial;
                quo_d = {quo_q[30:0], fits};
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(DW - 1)) begin
                    scale_d = {quo_q[30:0], fits};
                    ptr_d   = base_q;
                    state_d = NORM_RD;
                end
            end
            NORM_RD: begin
                if (!bus.avm_m0_waitrequest)
                    state_d = NORM_WT;
            end
            NORM_WT: begin
                if (bus.avm_m0_readdatavalid) begin
                    x_d     = rd_x;
                    state_d = NORM_WR;
                end
            end
            NORM_WR: begin
                if (!bus.avm_m0_waitrequest) begin
                    ptr_d   = ptr_inc;
                    state_d = last ? DONE : NORM_RD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus and status outputs decoded from the current state
    always_comb begin
        rd_en = (state_q == SCAN_RD) || (state_q == NORM_RD);
        wr_en = (state_q == NORM_WR);
        bus.avm_m0_read      = rd_en;
        bus.avm_m0_write     = wr_en;
        bus.avm_m0_address   = '0;
        bus.avm_m0_writedata = '0;
        if (rd_en || wr_en)
            bus.avm_m0_address = {ptr_q, 2'b00};
        if (wr_en)
            bus.avm_m0_writedata = {{16{y[15]}}, y};
        bus.busy = (state_q != IDLE) && (state_q != DONE);
        bus.done = (state_q == DONE);
        bus.peak = peak_q;
    end
endmodule
